multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back and drives the datapath control lines. It sits between the instruction register opcode field and the PC, instruction/data memory port, register file, ALU control and ALU operand muxes. Memory accesses use a ready handshake, so the block tolerates wait states. It also reports illegal opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- Run  in  1  start/continue; sampled in IDLE and at each instruction end
- Opcode  in  6  IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag, used only in BRANCH
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- ALUOp  out  2  00 add, 01 subtract, 10 use funct field
- ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- State  out  4  current state encoding, for debug
- IllegalOp  out  1  sticky; set on entry to TRAP
- InstRetired  out  CNT_W  retired-instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11, JUMP=12, TRAP=15.
- IDLE: all controls 0. Go to FETCH when Run=1.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. PCWrite and IRWrite equal MemReady. Hold in FETCH until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on Opcode:
  - 0 to R_EXEC
  - 35 or 43 to MEM_ADDR
  - 4 to BRANCH
  - 8 to ADDI_EXEC
  - 2 to JUMP (only when the jump feature is compiled in)
  - anything else to TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Opcode 35 goes to MEM_READ, opcode 43 goes to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until MemReady=1, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until MemReady=1.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. The PC update is the external AND of PCWriteCond and Zero.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- JUMP: PCWrite=1, PCSource=10.
- Terminal states are MEM_WB, MEM_WRITE (with MemReady=1), R_WB, BRANCH, ADDI_WB and JUMP. From a terminal state:
  - go to FETCH if Run=1, else IDLE
  - InstRetired increments by 1 and wraps modulo 2^CNT_W
- TRAP: all controls 0, IllegalOp=1. Leave TRAP only by reset.
- Any control not listed for a state is 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State=IDLE
  - all controls 0, IllegalOp=0, InstRetired=0
- Reset mid-instruction aborts immediately; no partial write is completed.
- Outputs are decoded combinationally from State. The only exceptions are PCWrite and IRWrite in FETCH, which are combinational in MemReady.
- Latency with MemReady tied high:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each wait cycle (MemReady=0) in FETCH, MEM_READ or MEM_WRITE adds 1 cycle. All outputs are held stable during the wait.
- MemReady is ignored in all states other than FETCH, MEM_READ and MEM_WRITE.
- Run=0 in a non-terminal state has no effect; the current instruction completes.

## Configuration
- MC_CTRL_JUMP_EN defined: opcode 2 dispatches to JUMP.
- MC_CTRL_JUMP_EN undefined:
  - the JUMP state is absent
  - opcode 2 goes to TRAP
  - PCSource never takes the value 10

## Test plan
- Reset low mid-FETCH, then release, Run=0: State=0, all outputs 0, InstRetired=0; holds IDLE.
- Run=1, MemReady=1, Opcode=0: states 1,2,7,8,1. RegWrite=1 and RegDst=1 in state 8. InstRetired=1.
- Opcode=35, MemReady low for 2 cycles in MEM_READ: states 1,2,3,4,4,4,5. MemRead and IorD held high across the wait. 7 cycles total.
- Opcode=4: PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH. Run=0 at BRANCH, so the next state is IDLE.
- Opcode=2:
  - with MC_CTRL_JUMP_EN: PCWrite=1, PCSource=10
  - without it: TRAP, IllegalOp=1, held until reset
- Opcode=63: TRAP, IllegalOp sticky; InstRetired unchanged. With CNT_W=4 and 16 retirements, InstRetired wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving datapath controls, with a
// retired-instruction counter and a sticky illegal-opcode flag. Define MC_CTRL_JUMP_EN for j.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Run,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstRetired
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFetch     = 4'd1,
    StDecode    = 4'd2,
    StMemAddr   = 4'd3,
    StMemRead   = 4'd4,
    StMemWb     = 4'd5,
    StMemWrite  = 4'd6,
    StRExec     = 4'd7,
    StRWb       = 4'd8,
    StBranch    = 4'd9,
    StAddiExec  = 4'd10,
    StAddiWb    = 4'd11,
`ifdef MC_CTRL_JUMP_EN
    StJump      = 4'd12,
`endif
    StTrap      = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // The branch PC update is gated by Zero outside this block.
  logic unused_zero;
  assign unused_zero = Zero;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StIdle:     if (Run) state_d = StFetch;
      StFetch:    if (MemReady) state_d = StDecode;
      StDecode: begin
        case (Opcode)
          6'd0:         state_d = StRExec;
          6'd35, 6'd43: state_d = StMemAddr;
          6'd4:         state_d = StBranch;
          6'd8:         state_d = StAddiExec;
`ifdef MC_CTRL_JUMP_EN
          6'd2:         state_d = StJump;
`endif
          default:      state_d = StTrap;
        endcase
      end
      StMemAddr:  state_d = (Opcode == 6'd35) ? StMemRead : StMemWrite;
      StMemRead:  if (MemReady) state_d = StMemWb;
      StMemWrite: retire = MemReady;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
`ifdef MC_CTRL_JUMP_EN
      StJump:     retire = 1'b1;
`endif
      StMemWb, StRWb, StBranch, StAddiWb: retire = 1'b1;
      StTrap:     state_d = StTrap;
      default:    state_d = StIdle;
    endcase
    if (retire) state_d = Run ? StFetch : StIdle;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      StDecode:   ALUSrcB = 2'b11;
      StMemAddr, StAddiExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StAddiWb:   RegWrite = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign State       = state_q;
  assign IllegalOp   = illegal_q;
  assign InstRetired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4 so the retire counter wrap is reachable).
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET, Run, Zero, MemReady;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;
  logic       IllegalOp;
  logic [3:0] InstRetired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .Run(Run), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .State(State), .IllegalOp(IllegalOp),
    .InstRetired(InstRetired)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,
  //  RegWrite,RegDst,PCSource,ALUOp,ALUSrcB}
  logic [15:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                 RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

  localparam logic [15:0] CFetchRdy = 16'h9401;
  localparam logic [15:0] CFetchWt  = 16'h1001;
  localparam logic [15:0] CDecode   = 16'h0003;
  localparam logic [15:0] CMemAddr  = 16'h0102;
  localparam logic [15:0] CMemRead  = 16'h3000;
  localparam logic [15:0] CMemWb    = 16'h0280;
  localparam logic [15:0] CMemWrite = 16'h2800;
  localparam logic [15:0] CRExec    = 16'h0108;
  localparam logic [15:0] CRWb      = 16'h00C0;
  localparam logic [15:0] CBranch   = 16'h4114;
  localparam logic [15:0] CAddiWb   = 16'h0080;
  localparam logic [15:0] CJump     = 16'h8020;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [15:0] c);
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    RESET = 1'b0; Run = 1'b0; Zero = 1'b0; MemReady = 1'b0; Opcode = 6'd0;
    #12 RESET = 1'b1;
    Run = 1'b1;
    step();
    expect_st("fetch_wait", 4'd1, CFetchWt);
    // Asynchronous reset in the middle of FETCH
    #2 RESET = 1'b0;
    #1;
    expect_st("reset", 4'd0, 16'h0000);
    check("reset.illegal", 32'(IllegalOp), 0);
    check("reset.retired", 32'(InstRetired), 0);
    @(negedge CLK);
    Run = 1'b0;
    RESET = 1'b1;
    step(); step();
    expect_st("idle_hold", 4'd0, 16'h0000);

    // R-type
    Run = 1'b1; MemReady = 1'b1; Opcode = 6'd0;
    step(); expect_st("r.fetch", 4'd1, CFetchRdy);
    step(); expect_st("r.decode", 4'd2, CDecode);
    step(); expect_st("r.exec", 4'd7, CRExec);
    step(); expect_st("r.wb", 4'd8, CRWb);
    check("r.retired_pre", 32'(InstRetired), 0);
    step(); expect_st("r.next", 4'd1, CFetchRdy);
    check("r.retired", 32'(InstRetired), 1);

    // lw with two wait states in MEM_READ
    Opcode = 6'd35;
    step(); expect_st("lw.decode", 4'd2, CDecode);
    step(); expect_st("lw.addr", 4'd3, CMemAddr);
    step(); MemReady = 1'b0; #1 expect_st("lw.read0", 4'd4, CMemRead);
    step(); expect_st("lw.read1", 4'd4, CMemRead);
    step(); expect_st("lw.read2", 4'd4, CMemRead);
    MemReady = 1'b1;
    step(); expect_st("lw.wb", 4'd5, CMemWb);
    step(); expect_st("lw.next", 4'd1, CFetchRdy);
    check("lw.retired", 32'(InstRetired), 2);

    // sw with one wait state
    Opcode = 6'd43;
    step(); expect_st("sw.decode", 4'd2, CDecode);
    step(); expect_st("sw.addr", 4'd3, CMemAddr);
    step(); MemReady = 1'b0; #1 expect_st("sw.write0", 4'd6, CMemWrite);
    step(); expect_st("sw.write1", 4'd6, CMemWrite);
    check("sw.retired_hold", 32'(InstRetired), 2);
    MemReady = 1'b1;
    step(); expect_st("sw.next", 4'd1, CFetchRdy);
    check("sw.retired", 32'(InstRetired), 3);

    // addi
    Opcode = 6'd8;
    step(); expect_st("addi.decode", 4'd2, CDecode);
    step(); expect_st("addi.exec", 4'd10, CMemAddr);
    step(); expect_st("addi.wb", 4'd11, CAddiWb);
    step(); expect_st("addi.next", 4'd1, CFetchRdy);
    check("addi.retired", 32'(InstRetired), 4);

    // beq, with Run dropped at BRANCH
    Opcode = 6'd4;
    step(); expect_st("beq.decode", 4'd2, CDecode);
    step(); expect_st("beq.branch", 4'd9, CBranch);
    Run = 1'b0;
    step(); expect_st("beq.idle", 4'd0, 16'h0000);
    check("beq.retired", 32'(InstRetired), 5);

    // Counter wrap: 11 more beq reach 16 retirements total
    Run = 1'b1;
    step(); expect_st("wrap.fetch", 4'd1, CFetchRdy);
    for (int i = 0; i < 11; i++) begin
      step(); step(); step();
      check($sformatf("wrap.retired%0d", i), 32'(InstRetired), 32'((5 + i + 1) % 16));
    end
    check("wrap.zero", 32'(InstRetired), 0);

    // Opcode 2
    Opcode = 6'd2;
    step(); expect_st("j.decode", 4'd2, CDecode);
`ifdef MC_CTRL_JUMP_EN
    step(); expect_st("j.jump", 4'd12, CJump);
    step(); expect_st("j.next", 4'd1, CFetchRdy);
    check("j.retired", 32'(InstRetired), 1);
    Opcode = 6'd63;
    step(); expect_st("ill.decode", 4'd2, CDecode);
    check("ill.flag_pre", 32'(IllegalOp), 0);
`endif
    step(); expect_st("trap", 4'd15, 16'h0000);
    check("trap.illegal", 32'(IllegalOp), 1);
`ifdef MC_CTRL_JUMP_EN
    check("trap.retired", 32'(InstRetired), 1);
`else
    check("trap.retired", 32'(InstRetired), 0);
`endif
    Run = 1'b0; MemReady = 1'b0;
    step(); step();
    Run = 1'b1;
    step(); expect_st("trap.hold", 4'd15, 16'h0000);
    check("trap.sticky", 32'(IllegalOp), 1);

    #2 RESET = 1'b0;
    #1;
    expect_st("reset2", 4'd0, 16'h0000);
    check("reset2.illegal", 32'(IllegalOp), 0);
    check("reset2.retired", 32'(InstRetired), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
